// File: rtl/ascii_cell_pkg.sv
// Shared constants and types for the ASCII cell mapper: default geometry, glyph table, FIFO entry.
package ascii_cell_pkg;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_CELL_W     = 8;
  localparam int DEF_CELL_H     = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int COLS  = DEF_H_ACTIVE / DEF_CELL_W;
  localparam int ROWS  = DEF_V_ACTIVE / DEF_CELL_H;
  localparam int SUM_W = 4 + $clog2(DEF_CELL_W * DEF_CELL_H);

  localparam int CODE_W = 8;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;

  // Index 0 (space) is the least significant byte; darkest glyph 'M' at index 15.
  localparam logic [15:0][7:0] GLYPH_LUT = {
    8'h4D, 8'h40, 8'h38, 8'h26, 8'h23, 8'h25, 8'h78, 8'h6F,
    8'h63, 8'h2A, 8'h2B, 8'h3D, 8'h2D, 8'h3A, 8'h2E, 8'h20
  };

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
  } char_entry_t;
endpackage

// File: rtl/ascii_cell_mapper_if.sv
// Glyph stream toward the character-buffer writer: valid/ready head of the output FIFO.
interface ascii_cell_mapper_if;
  import ascii_cell_pkg::*;

  logic              char_valid;
  logic              char_ready;
  logic [CODE_W-1:0] char_code;
  logic [COL_W-1:0]  char_col;
  logic [ROW_W-1:0]  char_row;

  modport master (output char_valid, char_code, char_col, char_row, input char_ready);
  modport slave  (input char_valid, char_code, char_col, char_row, output char_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO, head visible the cycle after the first push; push while full is
// ignored unless a pop happens the same cycle. dout holds the last popped word while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? last_q : mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ascii_cell_mapper.sv
// Accumulates 4-bit edge magnitudes per CELL_W x CELL_H cell and emits one ASCII glyph per cell.
// Glyph enters the FIFO 2 cycles after the cell's last pixel; on a full FIFO the result is dropped.
module ascii_cell_mapper
  import ascii_cell_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int CELL_W     = DEF_CELL_W,
  parameter int CELL_H     = DEF_CELL_H,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic [3:0]                 lsum,
  input  logic                       frame_sync,
  ascii_cell_mapper_if.master        char_if,
  output logic                       overflow
);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int LOG_W = $clog2(CELL_W);
  localparam int LOG_H = $clog2(CELL_H);
  localparam int NCOL  = H_ACTIVE / CELL_W;
  localparam int RS_W  = 4 + LOG_W;
  localparam int CS_W  = 4 + LOG_W + LOG_H;

  logic [XW-1:0]       x_cnt;
  logic [YW-1:0]       y_cnt;
  logic [RS_W-1:0]     row_sum;
  logic [CS_W-1:0]     acc [NCOL];

  logic [XW-LOG_W-1:0] col_idx;
  logic [LOG_W-1:0]    sub_x;
  logic [LOG_H-1:0]    sub_y;
  logic [YW-LOG_H-1:0] row_idx;
  logic                pix_vld;
  logic                line_end;
  logic                cell_done;
  logic [RS_W-1:0]     line_total;
  logic [CS_W-1:0]     acc_next;

  logic                s1_vld;
  logic [CS_W-1:0]     s1_sum;
  logic [COL_W-1:0]    s1_col;
  logic [ROW_W-1:0]    s1_row;
  logic                push_vld;
  char_entry_t         push_dat;

  char_entry_t         head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  assign col_idx = x_cnt[XW-1:LOG_W];
  assign sub_x   = x_cnt[LOG_W-1:0];
  assign sub_y   = y_cnt[LOG_H-1:0];
  assign row_idx = y_cnt[YW-1:LOG_H];

  always_comb begin
    pix_vld    = video_on && !frame_sync;
    line_end   = pix_vld && (sub_x == LOG_W'(CELL_W - 1));
    cell_done  = line_end && (sub_y == LOG_H'(CELL_H - 1));
    line_total = row_sum + RS_W'(lsum);
    // The first line of a cell starts from zero, so stale RAM contents never leak in.
    acc_next   = ((sub_y == '0) ? '0 : acc[col_idx]) + CS_W'(line_total);
  end

  always_ff @(posedge clock) begin
    if (!reset && line_end) acc[col_idx] <= acc_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      row_sum  <= '0;
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
      overflow <= 1'b0;
    end else begin
      if (frame_sync) begin
        x_cnt   <= '0;
        y_cnt   <= '0;
        row_sum <= '0;
      end else if (video_on) begin
        row_sum <= (sub_x == '0) ? RS_W'(lsum) : line_total;
        if (x_cnt == XW'(H_ACTIVE - 1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == YW'(V_ACTIVE - 1)) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      s1_vld <= cell_done;
      if (cell_done) begin
        s1_sum <= acc_next;
        s1_col <= COL_W'(col_idx);
        s1_row <= ROW_W'(row_idx);
      end

      // Mean over the cell is the top four bits of the cell sum.
      push_vld <= s1_vld;
      if (s1_vld) begin
        push_dat.code <= GLYPH_LUT[s1_sum[CS_W-1 -: 4]];
        push_dat.col  <= s1_col;
        push_dat.row  <= s1_row;
      end

      if (push_vld && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(char_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_vld),
    .din   (push_dat),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop                = char_if.char_valid && char_if.char_ready;
  assign char_if.char_valid = !fifo_empty;
  assign char_if.char_code  = head.code;
  assign char_if.char_col   = head.col;
  assign char_if.char_row   = head.row;
endmodule

// File: tb/tb_ascii_cell_mapper.sv
// Bench for ascii_cell_mapper on a reduced 128x48 frame: table-driven constant frames,
// a random frame against a cell-mean model, and hand sequences for latency, overflow and reset.
module tb_ascii_cell_mapper;
  localparam int H     = 128;
  localparam int V     = 48;
  localparam int CW    = 8;
  localparam int CH    = 16;
  localparam int DEPTH = 8;
  localparam int NC    = H / CW;
  localparam int NR    = V / CH;

  typedef struct packed {
    logic [7:0] code;
    logic [6:0] col;
    logic [5:0] row;
  } ent_t;

  typedef struct {
    int         lval;
    bit         gap;
    bit         rnd_rdy;
    logic [7:0] glyph;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       video_on;
  logic [3:0] lsum;
  logic       frame_sync;
  logic       overflow;

  ascii_cell_mapper_if cif ();

  ascii_cell_mapper #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .CELL_W     (CW),
    .CELL_H     (CH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .video_on   (video_on),
    .lsum       (lsum),
    .frame_sync (frame_sync),
    .char_if    (cif),
    .overflow   (overflow)
  );

  int    checks   = 0;
  int    failures = 0;
  bit    rand_ready = 0;
  int    img [V][H];
  ent_t  got [$];
  ent_t  exp [$];
  string GLYPHS = " .:-=+*cox%#&8@M";
  vec_t  vecs [4];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (!reset && cif.char_valid && cif.char_ready)
      got.push_back({cif.char_code, cif.char_col, cif.char_row});

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] l, input logic fs);
    video_on   = v;
    lsum       = l;
    frame_sync = fs;
    if (rand_ready) cif.char_ready = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, int'(cif.char_valid), 0);
    chk({nm, "_ovf"},   int'(overflow), 0);
    chk({nm, "_code"},  int'(cif.char_code), 0);
    chk({nm, "_col"},   int'(cif.char_col), 0);
    chk({nm, "_row"},   int'(cif.char_row), 0);
  endtask

  task automatic drive_img(input int y0, input int n, input bit gap);
    for (int y = y0; y < y0 + n; y++)
      for (int x = 0; x < H; x++) begin
        if (gap) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        step(1'b1, 4'(img[y][x]), 1'b0);
      end
  endtask

  task automatic fill_img(input int mode);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = (mode < 0) ? int'($urandom_range(0, 15)) : mode;
  endtask

  // Reference: mean of each cell of one cell row, mapped through the glyph string.
  task automatic build_exp(input int r);
    for (int c = 0; c < NC; c++) begin
      int sum = 0;
      for (int y = r * CH; y < (r + 1) * CH; y++)
        for (int x = c * CW; x < (c + 1) * CW; x++)
          sum += img[y][x];
      exp.push_back({8'(GLYPHS[sum / (CW * CH)]), 7'(c), 6'(r)});
    end
  endtask

  task automatic compare_q(input string nm);
    int t = 0;
    rand_ready = 0;
    cif.char_ready = 1'b1;
    while (got.size() < exp.size() && t < 3000) begin
      step(1'b0, 4'h0, 1'b0);
      t++;
    end
    repeat (10) step(1'b0, 4'h0, 1'b0);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s_code[%0d]", nm, i), int'(got[i].code), int'(exp[i].code));
      chk($sformatf("%s_col[%0d]", nm, i),  int'(got[i].col),  int'(exp[i].col));
      chk($sformatf("%s_row[%0d]", nm, i),  int'(got[i].row),  int'(exp[i].row));
    end
    got.delete();
    exp.delete();
  endtask

  initial begin
    vecs[0] = '{15, 1'b0, 1'b0, "M"};
    vecs[1] = '{0,  1'b0, 1'b0, " "};
    vecs[2] = '{4,  1'b1, 1'b0, "="};
    vecs[3] = '{8,  1'b0, 1'b1, "o"};

    reset = 1'b1;
    video_on = 1'b0;
    lsum = 4'h0;
    frame_sync = 1'b0;
    cif.char_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset();
    chk_reset("rst0");

    // Constant frames: every cell maps to the table glyph, row-major order.
    for (int k = 0; k < 4; k++) begin
      got.delete();
      exp.delete();
      cif.char_ready = 1'b1;
      step(1'b0, 4'h0, 1'b1);
      fill_img(vecs[k].lval);
      rand_ready = vecs[k].rnd_rdy;
      drive_img(0, V, vecs[k].gap);
      for (int i = 0; i < NC * NR; i++)
        exp.push_back({vecs[k].glyph, 7'(i % NC), 6'(i / NC)});
      compare_q($sformatf("const%0d", vecs[k].lval));
      chk($sformatf("const%0d_ovf", vecs[k].lval), int'(overflow), 0);
    end

    // Random frame; the frame_sync cycle carries a pixel that must be discarded.
    fill_img(-1);
    step(1'b1, 4'hF, 1'b1);
    rand_ready = 1;
    drive_img(0, V, 1'b0);
    for (int r = 0; r < NR; r++) build_exp(r);
    compare_q("rand");
    chk("rand_ovf", int'(overflow), 0);

    // Cell (0,0) half lit: mean 7 -> 'c', head valid three cycles after pixel (7,15).
    got.delete();
    cif.char_ready = 1'b0;
    step(1'b0, 4'h0, 1'b1);
    fill_img(0);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 15;
    drive_img(0, 15, 1'b0);
    for (int x = 0; x < 8; x++) step(1'b1, 4'(img[15][x]), 1'b0);
    chk("lat_n1", int'(cif.char_valid), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("lat_n2", int'(cif.char_valid), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("lat_n3", int'(cif.char_valid), 1);
    chk("c00_code", int'(cif.char_code), 'h63);
    chk("c00_col", int'(cif.char_col), 0);
    chk("c00_row", int'(cif.char_row), 0);

    // Backpressure over a whole cell row: DEPTH kept, rest dropped, overflow sticks.
    do_reset();
    chk_reset("rst1");
    got.delete();
    cif.char_ready = 1'b0;
    step(1'b0, 4'h0, 1'b1);
    fill_img(8);
    drive_img(0, CH, 1'b0);
    repeat (5) step(1'b0, 4'h0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_valid", int'(cif.char_valid), 1);
    for (int i = 0; i < DEPTH; i++) exp.push_back({8'h6F, 7'(i), 6'd0});
    compare_q("ovf");
    chk("ovf_sticky", int'(overflow), 1);

    // Mid-frame frame_sync restarts at (0,0).
    cif.char_ready = 1'b1;
    step(1'b0, 4'h0, 1'b1);
    fill_img(15);
    build_exp(0);
    drive_img(0, 20, 1'b0);
    for (int x = 0; x < 37; x++) step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b1);
    fill_img(-1);
    build_exp(0);
    drive_img(0, CH, 1'b0);
    compare_q("fsync");

    // Reset mid-cell with a full FIFO: everything clears, next row is clean.
    cif.char_ready = 1'b0;
    fill_img(15);
    drive_img(CH, CH, 1'b0);
    drive_img(2 * CH, 3, 1'b0);
    for (int x = 0; x < 11; x++) step(1'b1, 4'hF, 1'b0);
    chk("pre_rst_ovf", int'(overflow), 1);
    do_reset();
    chk_reset("rst2");
    fill_img(-1);
    build_exp(0);
    cif.char_ready = 1'b1;
    drive_img(0, CH, 1'b0);
    compare_q("post_rst");
    chk("post_rst_ovf", int'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascii_cell_mapper.md
Name: ascii_cell_mapper

Overview:
- Downstream stage of the Laplacian edge filter; consumes its 4-bit per-pixel edge magnitude (lsum) while video_on is high.
- Accumulates edge energy over CELL_W x CELL_H pixel cells of a H_ACTIVE x V_ACTIVE frame.
- At each completed cell, maps the mean magnitude to one of 16 ASCII glyph codes.
- Pushes the glyph code with its cell coordinates into an output FIFO with a valid/ready interface for the character-buffer writer.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- CELL_W, 8, cell width in pixels (power of 2)
- CELL_H, 16, cell height in lines (power of 2)
- FIFO_DEPTH, 16, output FIFO entries (power of 2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- video_on  in  1  qualifies lsum; one pixel per clock while high
- lsum  in  4  edge magnitude of the current pixel
- frame_sync  in  1  single-cycle pulse; next qualified pixel is pixel (0,0)
- char_valid  out  1  FIFO head valid
- char_ready  in  1  consumer accepts head when char_valid and char_ready are both high
- char_code  out  8  ASCII code at FIFO head
- char_col  out  7  cell column, 0..H_ACTIVE/CELL_W-1
- char_row  out  6  cell row, 0..V_ACTIVE/CELL_H-1
- overflow  out  1  sticky: a cell result was dropped because the FIFO was full

Behaviour:
- Reset: x_cnt=0, y_cnt=0, row_sum=0, FIFO empty, char_valid=0, overflow=0, char_code/col/row=0. Accumulator RAM is not cleared; the first line of each cell overwrites its entry.
- Counters:
  - x_cnt advances only on cycles with video_on=1.
  - At H_ACTIVE-1, x_cnt wraps to 0 and y_cnt increments.
  - y_cnt wraps to 0 after V_ACTIVE-1.
  - frame_sync forces x_cnt=y_cnt=0 and row_sum=0 and has priority over a same-cycle increment. The pixel qualified in the frame_sync cycle is discarded.
- Cell index: col=x_cnt/CELL_W, sub_x=x_cnt%CELL_W, sub_y=y_cnt%CELL_H, row=y_cnt/CELL_H.
- Horizontal accumulation:
  - row_sum (7 bits) = lsum when sub_x=0, else row_sum+lsum.
  - At sub_x=CELL_W-1: line_total = row_sum+lsum.
  - Then acc[col] (11-bit entry, H_ACTIVE/CELL_W entries) <= (sub_y==0 ? 0 : acc[col]) + line_total.
- Cell completion:
  - Occurs at sub_x=CELL_W-1 and sub_y=CELL_H-1.
  - cell_sum = acc[col] + line_total. Maximum is 15*128=1920, which fits in 11 bits; no saturation is needed.
  - cell_sum is registered in cycle N+1, where N is the final pixel cycle.
  - In cycle N+2: level = cell_sum >> log2(CELL_W*CELL_H), 0..15; glyph = GLYPH_LUT[level]; {glyph,col,row} is pushed.
  - char_valid is high in cycle N+3 if the FIFO was empty.
- GLYPH_LUT, indices 0..15 in order: space, '.', ':', '-', '=', '+', '*', 'c', 'o', 'x', '%', '#', '&', '8', '@', 'M'.
- FIFO:
  - First-word-fall-through; head is presented on char_code/col/row.
  - Pop on char_valid & char_ready.
  - Simultaneous push and pop when full is accepted; occupancy is unchanged.
  - Push when full and not popping: entry is dropped and overflow <= 1.
  - overflow clears only on reset.
  - Output fields hold their value while char_valid=0.
- Gaps in video_on stall all counters and accumulation; the pipeline stages (N+1, N+2) still advance.
- Reset mid-frame: all state returns to reset values; results of in-flight cells are lost.

Decomposition:
- Package ascii_cell_pkg holds:
  - GLYPH_LUT (16 x 8-bit constant)
  - derived widths: COLS=H_ACTIVE/CELL_W, ROWS=V_ACTIVE/CELL_H, SUM_W=4+log2(CELL_W*CELL_H)
  - typedef char_entry_t {code, col, row}
- Sub-module: sync_fifo_fwft (parameterised width and depth; push, pop, full, empty, dout). Reused for other stream stages.

Test Plan:
- Constant lsum=15, one full frame, char_ready=1 -> 2400 entries, all 'M' (0x4D), in order (col 0..79 within row 0..29).
- Constant lsum=0, full frame -> 2400 spaces (0x20); overflow stays 0.
- Cell (0,0): lsum=15 for lines 0..7, 0 for lines 8..15, other pixels 0 -> cell_sum=960, level 7, first entry 'c' (0x63) col0 row0. char_valid rises 3 cycles after pixel (7,15).
- char_ready=0 through cell row 0 with constant lsum=8 -> 16 entries held, 64 dropped, overflow=1. Then char_ready=1 -> 16 entries '8'? (level 8 -> 'o', 0x6F), cols 0..15.
- video_on toggling every other cycle with lsum=4 -> results identical to contiguous input: all '=' (level 4, 0x3D); no extra or missing entries.
- Assert frame_sync mid-frame, then reset asserted mid-cell -> frame_sync resumes counting at (0,0); after reset, FIFO is empty, overflow=0, and the first cell result after restart is correct (no stale accumulator contribution).
